topfinal: RTL and testbench

- Top-level minute/second countdown kitchen timer for the FPGA board.
- RSW (BCD rotary switch) selects the start time in whole minutes. PSW[0] starts and pauses the count.
- At 0:00 the buzzer and LEDs alarm until PSW[1] is pressed.
- Four 7-segment digits show "0M:SS"; a single 1 kHz board clock drives everything.

---
 rtl/topfinal.sv | 168 ++++++++++++++++
 tb/tb_topfinal.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/topfinal.sv
// Minute/second countdown kitchen timer: BCD time register, start/pause/reload
// control, 0:00 alarm with gated 500 Hz tone and flashing LEDs.
module topfinal #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int BEEP_HALF     = 250
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [3:0] PSW,
  input  logic [3:0] RSW,
  output logic [7:0] SEG_A,
  output logic [7:0] SEG_B,
  output logic [7:0] SEG_C,
  output logic [7:0] SEG_D,
  output logic [7:0] LED,
  output logic       BZ
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int BW = $clog2(BEEP_HALF + 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, ALARM} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] beep_q, beep_d;
  logic          gate_q, gate_d;
  logic          tone_q;
  logic [3:0]    min_q, min_d;
  logic [2:0]    s10_q, s10_d;
  logic [3:0]    s1_q, s1_d;
  logic [2:0]    sync1_q, sync2_q, sync3_q;
  logic [2:0]    pulse;
  logic [3:0]    rsw_min;
  logic [7:0]    therm;
  logic          unused_psw;

  assign unused_psw = PSW[3];
  assign pulse      = sync2_q & ~sync3_q;
  assign rsw_min    = (RSW > 4'd9) ? 4'd9 : RSW;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 8'b11111100;
      4'd1: seg7 = 8'b01100000;
      4'd2: seg7 = 8'b11011010;
      4'd3: seg7 = 8'b11110010;
      4'd4: seg7 = 8'b01100110;
      4'd5: seg7 = 8'b10110110;
      4'd6: seg7 = 8'b10111110;
      4'd7: seg7 = 8'b11100000;
      4'd8: seg7 = 8'b11111110;
      4'd9: seg7 = 8'b11110110;
      default: seg7 = 8'b00000000;
    endcase
  endfunction

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      presc_q <= '0;
      beep_q  <= '0;
      gate_q  <= 1'b0;
      tone_q  <= 1'b0;
      min_q   <= 4'd0;
      s10_q   <= 3'd0;
      s1_q    <= 4'd0;
      sync1_q <= 3'd0;
      sync2_q <= 3'd0;
      sync3_q <= 3'd0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      beep_q  <= beep_d;
      gate_q  <= gate_d;
      tone_q  <= ~tone_q;
      min_q   <= min_d;
      s10_q   <= s10_d;
      s1_q    <= s1_d;
      sync1_q <= PSW[2:0];
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // pulse[0]=start, [1]=stop, [2]=reload; stop outranks reload outranks start
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    beep_d  = beep_q;
    gate_d  = gate_q;
    min_d   = min_q;
    s10_d   = s10_q;
    s1_d    = s1_q;
    case (state_q)
      IDLE: begin
        min_d = rsw_min;
        s10_d = 3'd0;
        s1_d  = 4'd0;
        if (!pulse[1] && !pulse[2] && pulse[0] && rsw_min != 4'd0) begin
          state_d = RUN;
          presc_d = '0;
        end
      end
      RUN: begin
        if (pulse[1] || pulse[2]) begin
          state_d = IDLE;
        end else if (pulse[0]) begin
          state_d = PAUSE;
        end else if (presc_q == PW'(TICKS_PER_SEC - 1)) begin
          presc_d = '0;
          if (s1_q != 4'd0) begin
            s1_d = s1_q - 4'd1;
          end else if (s10_q != 3'd0) begin
            s10_d = s10_q - 3'd1;
            s1_d  = 4'd9;
          end else if (min_q != 4'd0) begin
            min_d = min_q - 4'd1;
            s10_d = 3'd5;
            s1_d  = 4'd9;
          end
          if (min_q == 4'd0 && s10_q == 3'd0 && s1_q == 4'd1) begin
            state_d = ALARM;
            beep_d  = '0;
            gate_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      PAUSE: begin
        if (pulse[1] || pulse[2]) state_d = IDLE;
        else if (pulse[0])        state_d = RUN;
      end
      ALARM: begin
        if (pulse[1]) begin
          state_d = IDLE;
        end else if (beep_q == BW'(BEEP_HALF - 1)) begin
          beep_d = '0;
          gate_d = ~gate_q;
        end else begin
          beep_d = beep_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_therm
    assign therm[gi] = (min_q > 4'(gi));
  end

  always_comb begin
    LED = 8'h00;
    case (state_q)
      RUN, PAUSE: LED = therm;
      ALARM:      LED = {8{gate_q}};
      default:    LED = 8'h00;
    endcase
  end

  assign BZ    = (state_q == ALARM) && gate_q && tone_q;
  assign SEG_A = seg7(4'd0);
  assign SEG_B = seg7(min_q);
  assign SEG_C = seg7({1'b0, s10_q});
  assign SEG_D = seg7(s1_q);

endmodule

// File: tb/tb_topfinal.sv
// Directed bench for topfinal with a fast prescaler and short beep half-period.
module tb_topfinal;
  logic       CLOCK = 1'b0;
  logic       RESET;
  logic [3:0] PSW;
  logic [3:0] RSW;
  logic [7:0] SEG_A, SEG_B, SEG_C, SEG_D, LED;
  logic       BZ;
  logic       b0, b1;
  int         checks = 0;
  int         errors = 0;

  always #5 CLOCK = ~CLOCK;

  topfinal #(.TICKS_PER_SEC(4), .BEEP_HALF(8)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .PSW(PSW), .RSW(RSW),
    .SEG_A(SEG_A), .SEG_B(SEG_B), .SEG_C(SEG_C), .SEG_D(SEG_D),
    .LED(LED), .BZ(BZ)
  );

  function automatic logic [7:0] seg(input int d);
    case (d)
      0: seg = 8'b11111100;
      1: seg = 8'b01100000;
      2: seg = 8'b11011010;
      3: seg = 8'b11110010;
      4: seg = 8'b01100110;
      5: seg = 8'b10110110;
      6: seg = 8'b10111110;
      7: seg = 8'b11100000;
      8: seg = 8'b11111110;
      9: seg = 8'b11110110;
      default: seg = 8'b00000000;
    endcase
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge CLOCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("[%0t] check %s observed %0h", $time, tag, obs);
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int m, input int t, input int u);
    check({tag, "/A"}, {24'd0, SEG_A}, {24'd0, seg(0)});
    check({tag, "/B"}, {24'd0, SEG_B}, {24'd0, seg(m)});
    check({tag, "/C"}, {24'd0, SEG_C}, {24'd0, seg(t)});
    check({tag, "/D"}, {24'd0, SEG_D}, {24'd0, seg(u)});
  endtask

  task automatic press(input int idx);
    PSW[idx] = 1'b1;
    step(1);
    PSW[idx] = 1'b0;
    step(2);
  endtask

  initial begin
    PSW = 4'd0;
    RSW = 4'd1;
    RESET = 1'b0;
    #1;
    step(3);
    check_time("reset", 0, 0, 0);
    check("reset_led", {24'd0, LED}, 32'h00);
    check("reset_bz", {31'd0, BZ}, 32'd0);
    RESET = 1'b1;
    step(3);
    check_time("idle_rsw1", 1, 0, 0);
    check("idle_led", {24'd0, LED}, 32'h00);
    check("idle_bz", {31'd0, BZ}, 32'd0);

    press(0);
    check_time("run_entry", 1, 0, 0);
    check("run_led_m1", {24'd0, LED}, 32'h01);
    step(4);
    check_time("run_059", 0, 5, 9);
    check("run_led_m0", {24'd0, LED}, 32'h00);
    step(4);
    check_time("run_058", 0, 5, 8);
    step(4);
    check_time("run_057", 0, 5, 7);

    press(0);
    check_time("pause_entry", 0, 5, 7);
    step(50);
    check_time("pause_held", 0, 5, 7);
    check("pause_bz", {31'd0, BZ}, 32'd0);
    press(0);
    check_time("resume_0", 0, 5, 7);
    step(1);
    check_time("resume_1", 0, 5, 7);
    step(1);
    check_time("resume_056", 0, 5, 6);

    step(220);
    check_time("run_001", 0, 0, 1);
    step(3);
    check_time("run_001_hold", 0, 0, 1);
    check("pre_alarm_bz", {31'd0, BZ}, 32'd0);
    step(1);
    check_time("alarm_000", 0, 0, 0);
    check("alarm_led_on", {24'd0, LED}, 32'hFF);
    b0 = BZ;
    step(1);
    b1 = BZ;
    check("alarm_bz_toggle", {31'd0, b0 ^ b1}, 32'd1);
    check("alarm_led_on2", {24'd0, LED}, 32'hFF);
    step(6);
    check("alarm_led_last_on", {24'd0, LED}, 32'hFF);
    step(1);
    check("alarm_led_off", {24'd0, LED}, 32'h00);
    check("alarm_bz_off", {31'd0, BZ}, 32'd0);
    step(1);
    check("alarm_bz_off2", {31'd0, BZ}, 32'd0);
    step(7);
    check("alarm_led_on_again", {24'd0, LED}, 32'hFF);

    press(1);
    check("stop_bz", {31'd0, BZ}, 32'd0);
    check("stop_led", {24'd0, LED}, 32'h00);
    step(1);
    check_time("stop_reload_100", 1, 0, 0);

    RSW = 4'd0;
    step(2);
    check_time("rsw0_idle", 0, 0, 0);
    press(0);
    step(10);
    check_time("rsw0_start_ignored", 0, 0, 0);
    check("rsw0_bz", {31'd0, BZ}, 32'd0);
    check("rsw0_led", {24'd0, LED}, 32'h00);
    RSW = 4'd12;
    step(1);
    check_time("rsw12_clamp", 9, 0, 0);

    RSW = 4'd9;
    press(0);
    check_time("run9_entry", 9, 0, 0);
    check("run9_led_cap", {24'd0, LED}, 32'hFF);
    step(4);
    check_time("run9_859", 8, 5, 9);
    check("run9_led_m8", {24'd0, LED}, 32'hFF);
    step(4);
    check_time("run9_858", 8, 5, 8);
    #2;
    RESET = 1'b0;
    #1;
    check_time("async_reset", 0, 0, 0);
    check("async_reset_led", {24'd0, LED}, 32'h00);
    check("async_reset_bz", {31'd0, BZ}, 32'd0);
    step(2);
    RESET = 1'b1;
    step(1);
    check_time("post_reset_idle", 9, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
